// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch predict unit: counter encodings,
// recovery FSM states and the sequential PC step.
package branch_predict_unit_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } bpu_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Combinational next value of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predict_unit_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_cnt;
        if (i_taken) begin
            if (i_cnt != ST) o_next = i_cnt + 2'd1;
        end else begin
            if (i_cnt != SNT) o_next = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB predictor with mispredict recovery for the fetch stage.
// Optional BPU_STATS_EN adds branch and mispredict event counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         IDX_W    = 4,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        stage_clk,
    input  logic        reset,
    input  logic        stage_ena,
    input  logic [31:0] pc_fetch,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred,
    output logic        branch_prediction,
    output logic        take_new_pc,
    output logic [31:0] pc_new,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        mispredict
`ifdef BPU_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + 2 + TAG_W - 1;

    logic             r_valid  [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [1:0]       r_cnt    [DEPTH];
    bpu_state_e       r_state;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_pred;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_upd;
    logic             w_mp;
    logic [1:0]       w_cnt_next;
    logic             w_unused_pc;

    assign w_f_idx   = pc_fetch[IDX_W+1:2];
    assign w_f_tag   = pc_fetch[TAG_HI:TAG_LO];
    assign w_f_pred  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag) && r_cnt[w_f_idx][1];

    assign w_ex_idx  = ex_pc[IDX_W+1:2];
    assign w_ex_tag  = ex_pc[TAG_HI:TAG_LO];
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd     = stage_ena && ex_valid && ex_is_branch;
    assign w_mp      = ex_valid && ex_is_branch && (ex_pred != ex_taken);

    assign w_unused_pc = ^{pc_fetch[31:TAG_HI+1], pc_fetch[1:0]};

    sat_counter2 u_sat_counter2 (
        .i_cnt   (r_cnt[w_ex_idx]),
        .i_taken (ex_taken),
        .o_next  (w_cnt_next)
    );

    // Mispredict recovery outranks the RECOVER squash, which outranks a predicted redirect.
    always_comb begin
        branch_prediction = 1'b0;
        take_new_pc       = 1'b0;
        pc_new            = 32'd0;
        flush_fd          = 1'b0;
        flush_de          = 1'b0;
        if (w_mp) begin
            take_new_pc = 1'b1;
            pc_new      = ex_taken ? ex_target : ex_pc + PC_STEP;
            flush_fd    = 1'b1;
            flush_de    = 1'b1;
        end else if (r_state == RECOVER) begin
            flush_de = 1'b1;
        end else if (w_f_pred) begin
            branch_prediction = 1'b1;
            take_new_pc       = 1'b1;
            pc_new            = r_target[w_f_idx];
        end
    end

    // Same-index lookups see the pre-update entry; there is no write bypass.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_cnt[i]    <= CNT_INIT;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                r_cnt[w_ex_idx] <= w_cnt_next;
                if (ex_taken) r_target[w_ex_idx] <= ex_target;
            end else if (ex_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_cnt[w_ex_idx]    <= WT;
            end
        end
    end

    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            mispredict <= 1'b0;
        end else if (stage_ena) begin
            mispredict <= w_mp;
            case (r_state)
                IDLE:    r_state <= w_mp ? RECOVER : IDLE;
                RECOVER: r_state <= w_mp ? RECOVER : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            stat_branches <= 32'd0;
            stat_mispred  <= 32'd0;
        end else if (stage_ena) begin
            if (w_upd) stat_branches <= stat_branches + 32'd1;
            if (w_mp)  stat_mispred  <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios then random
// traffic compared against a behavioural table model. Honours BPU_STATS_EN.
module tb_branch_predict_unit;

    localparam int DEPTH = 16;

    logic        stage_clk = 1'b0;
    logic        reset = 1'b1;
    logic        stage_ena = 1'b1;
    logic [31:0] pc_fetch = 32'h40;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        ex_pred = 1'b0;
    logic        branch_prediction, take_new_pc, flush_fd, flush_de, mispredict;
    logic [31:0] pc_new;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    branch_predict_unit dut (
        .stage_clk(stage_clk), .reset(reset), .stage_ena(stage_ena),
        .pc_fetch(pc_fetch), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred(ex_pred),
        .branch_prediction(branch_prediction), .take_new_pc(take_new_pc), .pc_new(pc_new),
        .flush_fd(flush_fd), .flush_de(flush_de), .mispredict(mispredict)
`ifdef BPU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 stage_clk = ~stage_clk;

    int n_checks = 0;
    int n_pass = 0;

    // reference model state
    bit          m_valid  [DEPTH];
    int          m_tag    [DEPTH];
    logic [31:0] m_target [DEPTH];
    int          m_cnt    [DEPTH];
    bit          m_recover;
    bit          m_misp;
    logic [31:0] m_branches, m_mispred;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else n_pass++;
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 6) & 32'hFF);
    endfunction

    function automatic bit model_mp();
        return ex_valid && ex_is_branch && (ex_pred != ex_taken);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 32'd0; m_cnt[i] = 1;
        end
        m_recover = 0; m_misp = 0; m_branches = 0; m_mispred = 0;
    endtask

    task automatic check_comb();
        bit mp, pred;
        int fi;
        logic [31:0] e_pc;
        logic e_bp, e_take, e_ffd, e_fde;
        mp = model_mp();
        fi = idx_of(pc_fetch);
        pred = m_valid[fi] && (m_tag[fi] == tag_of(pc_fetch)) && (m_cnt[fi] >= 2);
        e_bp = 0; e_take = 0; e_ffd = 0; e_fde = 0; e_pc = 32'd0;
        if (mp) begin
            e_take = 1; e_ffd = 1; e_fde = 1;
            e_pc = ex_taken ? ex_target : ex_pc + 32'd4;
        end else if (m_recover) begin
            e_fde = 1;
        end else if (pred) begin
            e_bp = 1; e_take = 1; e_pc = m_target[fi];
        end
        check("branch_prediction", {31'd0, branch_prediction}, {31'd0, e_bp});
        check("take_new_pc", {31'd0, take_new_pc}, {31'd0, e_take});
        check("pc_new", pc_new, e_pc);
        check("flush_fd", {31'd0, flush_fd}, {31'd0, e_ffd});
        check("flush_de", {31'd0, flush_de}, {31'd0, e_fde});
    endtask

    task automatic model_clock();
        bit mp;
        int ei;
        mp = model_mp();
        ei = idx_of(ex_pc);
        if (!stage_ena) return;
        if (ex_valid && ex_is_branch) begin
            m_branches = m_branches + 32'd1;
            if (m_valid[ei] && m_tag[ei] == tag_of(ex_pc)) begin
                m_cnt[ei] = ex_taken ? ((m_cnt[ei] == 3) ? 3 : m_cnt[ei] + 1)
                                     : ((m_cnt[ei] == 0) ? 0 : m_cnt[ei] - 1);
                if (ex_taken) m_target[ei] = ex_target;
            end else if (ex_taken) begin
                m_valid[ei] = 1; m_tag[ei] = tag_of(ex_pc);
                m_target[ei] = ex_target; m_cnt[ei] = 2;
            end
        end
        if (mp) m_mispred = m_mispred + 32'd1;
        m_recover = mp;
        m_misp = mp;
    endtask

    task automatic check_regs();
        check("mispredict", {31'd0, mispredict}, {31'd0, m_misp});
`ifdef BPU_STATS_EN
        check("stat_branches", stat_branches, m_branches);
        check("stat_mispred", stat_mispred, m_mispred);
`endif
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input bit ena, input logic [31:0] pcf, input bit ev, input bit eb,
                        input logic [31:0] epc, input bit et, input logic [31:0] etgt, input bit ep);
        stage_ena = ena; pc_fetch = pcf; ex_valid = ev; ex_is_branch = eb;
        ex_pc = epc; ex_taken = et; ex_target = etgt; ex_pred = ep;
        #2;
        check_comb();
        @(posedge stage_clk);
        model_clock();
        #1;
        check_regs();
    endtask

    task automatic idle_step(input logic [31:0] pcf);
        step(1, pcf, 0, 0, 32'd0, 0, 32'd0, 0);
    endtask

    task automatic async_reset();
        ex_valid = 0;
        #1;
        reset = 1;
        #1;
        model_reset();
        check_comb();
        check_regs();
        #1;
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [6];
        model_reset();
        #2;
        check_comb();
        check_regs();
        check("reset_pred_0x40", {31'd0, branch_prediction}, 32'd0);
        #10;
        reset = 0;
        @(posedge stage_clk);
        #1;

        // train 0x40 taken via a mispredict
        step(1, 32'h40, 1, 1, 32'h40, 1, 32'h80, 0);
        check("first_mp_mispredict", {31'd0, mispredict}, 32'd1);
        idle_step(32'h40);
        idle_step(32'h40);
        #0;
        // prediction for 0x40 in IDLE after allocation
        stage_ena = 1; pc_fetch = 32'h40; #1;
        check("pred_0x40_after_alloc", {31'd0, branch_prediction}, 32'd1);
        check("pc_new_0x80", pc_new, 32'h80);
        @(posedge stage_clk); model_clock(); #1;

        // not taken twice, predicted taken
        step(1, 32'h40, 1, 1, 32'h40, 0, 32'h80, 1);
        idle_step(32'h40);
        step(1, 32'h40, 1, 1, 32'h40, 0, 32'h80, 1);
        idle_step(32'h40);
        idle_step(32'h40);

        // alias replaces the entry
        step(1, 32'h40, 1, 1, 32'h440, 1, 32'h200, 0);
        idle_step(32'h40);
        idle_step(32'h40);
        idle_step(32'h440);

        // frozen pipeline with a mispredict present
        step(0, 32'h440, 1, 1, 32'h440, 0, 32'h0, 1);
        check("frozen_mispredict_held", {31'd0, mispredict}, 32'd0);
        idle_step(32'h440);

        // reset while recovering
        step(1, 32'h440, 1, 1, 32'h80, 1, 32'h300, 0);
        async_reset();
        check("post_reset_flush_de", {31'd0, flush_de}, 32'd0);
        @(posedge stage_clk); #1;
        idle_step(32'h440);

        // random traffic over a small PC pool so entries hit, alias and saturate
        for (int i = 0; i < 6; i++)
            pcs[i] = (32'(i % 3) << 6) | (32'(i % 2) << 2) | ((i == 5) ? 32'h0010_0000 : 32'd0);
        for (int n = 0; n < 1500; n++) begin
            bit ev, eb, et, ep, en;
            en = ($urandom_range(0, 9) != 0);
            ev = ($urandom_range(0, 3) != 0);
            eb = ($urandom_range(0, 3) != 0);
            et = $urandom_range(0, 1);
            ep = ($urandom_range(0, 2) == 0) ? ~et : et;
            step(en, pcs[$urandom_range(0, 5)], ev, eb, pcs[$urandom_range(0, 5)], et,
                 $urandom & 32'hFFFF_FFFC, ep);
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                @(posedge stage_clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
